// File: rtl/alu_8_bit.sv
// Registered 8-bit ALU: one op per accepted cycle, result
// and Carry/Zero/Negative/Overflow/Parity flags one cycle later.
module alu_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Parity
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             cry;
  logic             ovf;

  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
    res  = '0;
    cry  = 1'b0;
    ovf  = 1'b0;
    unique case (ALU_Sel)
      3'b000: begin
        res = sum[MSB:0];
        cry = sum[WIDTH];
        ovf = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
      end
      3'b001: begin
        // diff[WIDTH] is set exactly when A < B (borrow)
        res = diff[MSB:0];
        cry = diff[WIDTH];
        ovf = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
      end
      3'b010: begin
        res = {A[MSB-1:0], 1'b0};
        cry = A[MSB];
      end
      3'b011: begin
        res = {1'b0, A[MSB:1]};
        cry = A[0];
      end
      3'b100: res = A ^ B;
      3'b101: res = A & B;
      3'b110: res = A | B;
      3'b111: res = ~A;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Overflow  <= 1'b0;
      Parity    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out  <= res;
        Carry    <= cry;
        Zero     <= (res == '0);
        Negative <= res[MSB];
        Overflow <= ovf;
        Parity   <= ^res;
      end
    end
  end

endmodule

// File: tb/tb_alu_8_bit.sv
// Scoreboard bench for alu_8_bit: directed table from the
// spec examples plus randomized ops against an integer model.
module tb_alu_8_bit;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       p;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [2:0] ALU_Sel = 3'b000;
  logic       out_valid;
  logic [7:0] ALU_Out;
  logic       Carry, Zero, Negative, Overflow, Parity;

  resp_t exp_q[$];
  resp_t hold = '0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  alu_8_bit #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .ALU_Sel(ALU_Sel),
    .out_valid(out_valid),
    .ALU_Out(ALU_Out),
    .Carry(Carry),
    .Zero(Zero),
    .Negative(Negative),
    .Overflow(Overflow),
    .Parity(Parity)
  );

  // Reference model in plain integer arithmetic.
  function automatic resp_t model(input logic [2:0] s,
                                  input logic [7:0] a,
                                  input logic [7:0] b);
    int ua, ub, sa, sb, t, r, ones;
    bit c, v;
    resp_t e;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (s)
      3'd0: begin
        t = ua + ub;
        r = t % 256;
        c = (t > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        t = ua - ub;
        r = (t + 256) % 256;
        c = (ua < ub);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: begin
        r = (ua * 2) % 256;
        c = (ua > 127);
      end
      3'd3: begin
        r = ua / 2;
        c = (ua % 2) == 1;
      end
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(a & b);
      3'd6: r = int'(a | b);
      default: r = 255 - ua;
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (r >> i) % 2;
    e.r = 8'(r);
    e.c = c;
    e.z = (r == 0);
    e.n = (r >= 128);
    e.v = v;
    e.p = (ones % 2) == 1;
    return e;
  endfunction

  task automatic issue(input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b, input resp_t e);
    @(negedge clk);
    in_valid = 1'b1;
    ALU_Sel  = s;
    A        = a;
    B        = b;
    if (!rst) exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    ALU_Sel  = 3'($urandom);
    A        = 8'($urandom);
    B        = 8'($urandom);
  endtask

  task automatic rnd_op();
    logic [2:0] s;
    logic [7:0] a, b;
    s = 3'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
    issue(s, a, b, model(s, a, b));
  endtask

  // Monitor: pops an expectation whenever the DUT shows a result.
  initial begin
    resp_t got, e;
    forever begin
      @(posedge clk);
      #1;
      got = {ALU_Out, Carry, Zero, Negative, Overflow, Parity};
      checks++;
      if (rst) begin
        hold = '0;
        if (out_valid !== 1'b0 || got !== resp_t'(0)) begin
          errors++;
          $display("FAIL reset: out_valid=%b got=%h required all zero",
                   out_valid, got);
        end
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: got=%h with no op pending", got);
        end else begin
          e = exp_q.pop_front();
          hold = e;
          if (got !== e) begin
            errors++;
            $display("FAIL result: got r=%h c%b z%b n%b v%b p%b required r=%h c%b z%b n%b v%b p%b",
                     got.r, got.c, got.z, got.n, got.v, got.p,
                     e.r, e.c, e.z, e.n, e.v, e.p);
          end
        end
      end else begin
        if (out_valid !== 1'b0 || exp_q.size() != 0 || got !== hold) begin
          errors++;
          $display("FAIL idle_hold: out_valid=%b pending=%0d got=%h required=%h",
                   out_valid, exp_q.size(), got, hold);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    // Reset two cycles, then an op under reset that must vanish.
    idle();
    idle();
    issue(3'd0, 8'd10, 8'd20, model(3'd0, 8'd10, 8'd20));
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle();
    // Directed cases, back to back.
    issue(3'd0, 8'd100, 8'd50, '{8'h96, 0, 0, 1, 1, 0});
    issue(3'd0, 8'd127, 8'd1,  '{8'h80, 0, 0, 1, 1, 1});
    issue(3'd0, 8'd255, 8'd1,  '{8'h00, 1, 1, 0, 0, 0});
    issue(3'd1, 8'd50, 8'd100, '{8'hCE, 1, 0, 1, 0, 1});
    issue(3'd1, 8'h80, 8'h01,  '{8'h7F, 0, 0, 0, 1, 1});
    issue(3'd1, 8'h00, 8'h01,  '{8'hFF, 1, 0, 1, 0, 0});
    issue(3'd1, 8'h37, 8'h37,  '{8'h00, 0, 1, 0, 0, 0});
    issue(3'd2, 8'h9B, 8'h5A,  '{8'h36, 1, 0, 0, 0, 0});
    issue(3'd3, 8'h9B, 8'h5A,  '{8'h4D, 1, 0, 0, 0, 0});
    issue(3'd5, 8'hCC, 8'hAA,  '{8'h88, 0, 0, 1, 0, 0});
    issue(3'd6, 8'hCC, 8'hAA,  '{8'hEE, 0, 0, 1, 0, 0});
    issue(3'd4, 8'hCC, 8'hAA,  '{8'h66, 0, 0, 0, 0, 0});
    issue(3'd7, 8'hCC, 8'hAA,  '{8'h33, 0, 0, 0, 0, 0});
    idle();
    idle();
    // Randomized traffic with gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0) rnd_op();
      else idle();
    end
    // Reset mid-stream with an op in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle();
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(3) != 0) rnd_op();
      else idle();
    end
    idle();
    idle();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
